// File: rtl/count_seq_monitor_pkg.sv
// Shared types and default widths for the count sequence monitor.
package count_seq_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } mon_state_e;

    localparam int WIDTH_DEF     = 4;
    localparam int START_VAL_DEF = 1;
    localparam int ERR_CNT_W_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear takes effect before
// a same-cycle increment, so clr+inc yields 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d, base;

    always_comb begin
        base = clr ? '0 : q_q;
        q_d  = base;
        if (inc && (base != '1)) q_d = base + W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_q <= '0;
        else          q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/count_seq_monitor.sv
// In-line checker that the upstream counter steps by exactly one each enabled cycle.
// Define COUNT_SEQ_MONITOR_SVA_EN to elaborate the embedded assertions and covers.
module count_seq_monitor
    import count_seq_monitor_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int START_VAL = START_VAL_DEF,
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     count_i,
    input  logic                 enable_i,
    input  logic                 clr_i,
    output logic                 err_o,
    output logic                 err_sticky_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 wrap_o,
    output logic [WIDTH-1:0]     exp_o,
    output logic [1:0]           state_o
);

    localparam logic [WIDTH-1:0] START_C = WIDTH'(START_VAL);

    mon_state_e       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] count_inc;

    assign count_inc = count_i + WIDTH'(1);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: if (enable_i) begin
                err_d   = (count_i != START_C);
                exp_d   = count_inc;
                state_d = RUN;
            end
            // Always resync to the observed value so one glitch costs one error.
            RUN: if (enable_i) begin
                err_d  = (count_i != exp_q);
                wrap_d = (exp_q == '0) && (count_i == '0);
                exp_d  = count_inc;
            end else begin
                state_d = HOLD;
            end
            HOLD: if (enable_i) begin
                exp_d   = count_inc;
                state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        sticky_d = (clr_i ? 1'b0 : sticky_q) | err_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
            sticky_q <= sticky_d;
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_i),
        .inc     (err_d),
        .q       (err_cnt_o)
    );

    assign err_o        = err_q;
    assign err_sticky_o = sticky_q;
    assign wrap_o       = wrap_q;
    assign exp_o        = exp_q;
    assign state_o      = state_q;

`ifdef COUNT_SEQ_MONITOR_SVA_EN
    a_state_legal: assert property (@(posedge clk) disable iff (!reset_n)
        state_q inside {IDLE, RUN, HOLD});
    a_err_sticky: assert property (@(posedge clk) disable iff (!reset_n)
        err_o |-> err_sticky_o);
    a_cnt_mono: assert property (@(posedge clk) disable iff (!reset_n)
        !clr_i |=> (err_cnt_o >= $past(err_cnt_o)));
    a_no_err_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == HOLD) |-> !err_o);
    c_wrap: cover property (@(posedge clk) disable iff (!reset_n) wrap_o);
    c_start_mismatch: cover property (@(posedge clk) disable iff (!reset_n)
        (state_q == IDLE) && enable_i && (count_i != START_C));
`endif

endmodule

// File: tb/tb_count_seq_monitor.sv
// Randomized and directed bench for count_seq_monitor against a history-based reference model.
module tb_count_seq_monitor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [3:0] count_i = '0;

    logic       err8, stk8, wrap8;
    logic [7:0] cnt8;
    logic [3:0] exp8;
    logic [1:0] st8;
    logic       err2, stk2, wrap2;
    logic [1:0] cnt2;
    logic [3:0] exp2;
    logic [1:0] st2;

    count_seq_monitor dut8 (
        .clk(clk), .reset_n(reset_n), .count_i(count_i), .enable_i(enable_i), .clr_i(clr_i),
        .err_o(err8), .err_sticky_o(stk8), .err_cnt_o(cnt8), .wrap_o(wrap8),
        .exp_o(exp8), .state_o(st8));

    count_seq_monitor #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .count_i(count_i), .enable_i(enable_i), .clr_i(clr_i),
        .err_o(err2), .err_sticky_o(stk2), .err_cnt_o(cnt2), .wrap_o(wrap2),
        .exp_o(exp2), .state_o(st2));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit run_chk = 0;

    // Reference model: tracks sampling history, not the FSM.
    bit m_seen, m_prev_en, m_err, m_wrap, m_sticky;
    int m_last, m_cnt, m_state;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int m_exp();
        return m_seen ? ((m_last + 1) % 16) : 0;
    endfunction

    task automatic model_reset();
        m_seen = 0; m_prev_en = 0; m_err = 0; m_wrap = 0; m_sticky = 0;
        m_last = 0; m_cnt = 0; m_state = 0;
    endtask

    task automatic model_update(input bit en, input int c, input bit cl);
        m_err = 0;
        m_wrap = 0;
        if (cl) begin
            m_cnt = 0;
            m_sticky = 0;
        end
        if (en) begin
            if (!m_seen) m_err = (c != 1);
            else if (m_prev_en) begin
                m_err  = (c != (m_last + 1) % 16);
                m_wrap = (m_last == 15) && (c == 0);
            end
            m_last = c;
            m_seen = 1;
            m_state = 1;
        end else begin
            m_state = m_seen ? 2 : 0;
        end
        if (m_err) begin
            m_cnt++;
            m_sticky = 1;
        end
        m_prev_en = en;
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            chk("err", 32'(err8), 32'(m_err));
            chk("wrap", 32'(wrap8), 32'(m_wrap));
            chk("sticky", 32'(stk8), 32'(m_sticky));
            chk("exp", 32'(exp8), 32'(m_exp()));
            chk("state", 32'(st8), 32'(m_state));
            chk("cnt8", 32'(cnt8), 32'(sat(m_cnt, 8)));
            chk("cnt2", 32'(cnt2), 32'(sat(m_cnt, 2)));
            chk("err_w2", 32'(err2), 32'(m_err));
            chk("sticky_w2", 32'(stk2), 32'(m_sticky));
            chk("state_w2", 32'(st2), 32'(m_state));
        end
    end

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit en, input logic [3:0] c, input bit cl);
        enable_i = en;
        count_i  = c;
        clr_i    = cl;
        @(posedge clk);
        model_update(en, int'(c), cl);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset_n  = 1'b0;
        enable_i = 1'b0;
        clr_i    = 1'b0;
        model_reset();
        #1;
        chk("rst_err", 32'(err8), 0);
        chk("rst_sticky", 32'(stk8), 0);
        chk("rst_cnt", 32'(cnt8), 0);
        chk("rst_wrap", 32'(wrap8), 0);
        chk("rst_exp", 32'(exp8), 0);
        chk("rst_state", 32'(st8), 0);
        chk("rst_cnt2", 32'(cnt2), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] c;
        do_reset();
        run_chk = 1;

        // Clean run through a wrap.
        for (int i = 1; i <= 15; i++) step(1'b1, 4'(i), 1'b0);
        chk("t1_wrap_before", 32'(wrap8), 0);
        step(1'b1, 4'd0, 1'b0);
        chk("t1_wrap", 32'(wrap8), 1);
        step(1'b1, 4'd1, 1'b0);
        chk("t1_wrap_after", 32'(wrap8), 0);
        chk("t1_sticky", 32'(stk8), 0);

        // Bad first sample.
        do_reset();
        step(1'b1, 4'd3, 1'b0);
        chk("t2_err", 32'(err8), 1);
        chk("t2_cnt", 32'(cnt8), 1);
        chk("t2_exp", 32'(exp8), 4);
        step(1'b1, 4'd4, 1'b0);
        chk("t2_err4", 32'(err8), 0);
        step(1'b1, 4'd5, 1'b0);
        chk("t2_err5", 32'(err8), 0);

        // Single glitch in RUN gives one error.
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, 4'(i), 1'b0);
        step(1'b1, 4'd9, 1'b0);
        chk("t3_err9", 32'(err8), 1);
        chk("t3_sticky", 32'(stk8), 1);
        step(1'b1, 4'd10, 1'b0);
        chk("t3_err10", 32'(err8), 0);
        chk("t3_cnt", 32'(cnt8), 1);

        // Hold while the counter jumps.
        do_reset();
        for (int i = 1; i <= 7; i++) step(1'b1, 4'(i), 1'b0);
        step(1'b0, 4'd8, 1'b0);
        step(1'b0, 4'd10, 1'b0);
        step(1'b0, 4'd11, 1'b0);
        chk("t4_hold", 32'(st8), 2);
        step(1'b1, 4'd12, 1'b0);
        chk("t4_err12", 32'(err8), 0);
        step(1'b1, 4'd13, 1'b0);
        chk("t4_err13", 32'(err8), 0);
        chk("t4_state", 32'(st8), 1);
        chk("t4_sticky", 32'(stk8), 0);

        // Saturation, then clear with a same-cycle mismatch.
        do_reset();
        step(1'b1, 4'd3, 1'b0);
        step(1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        chk("t5_sat2", 32'(cnt2), 3);
        chk("t5_cnt8", 32'(cnt8), 5);
        step(1'b1, 4'd8, 1'b1);
        chk("t5_clr_cnt2", 32'(cnt2), 1);
        chk("t5_clr_cnt8", 32'(cnt8), 1);
        chk("t5_clr_sticky", 32'(stk2), 1);

        // Reset mid-RUN, then restart at START_VAL.
        do_reset();
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        do_reset();
        step(1'b1, 4'd1, 1'b0);
        chk("t6_err", 32'(err8), 0);
        chk("t6_state", 32'(st8), 1);

        // Randomized traffic.
        c = 4'($urandom_range(15));
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) < 10) c = 4'($urandom_range(15));
            else                         c = c + 4'd1;
            if ($urandom_range(199) == 0) do_reset();
            step($urandom_range(99) < 85, c, $urandom_range(99) < 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
